// File: rtl/booths_multiplication.sv
// Sequential signed multiplier using radix-2 Booth recoding, one step per clock.
// Product valid N cycles after accept; start is ignored while busy (no queuing).
module booths_multiplication #(
  parameter int N = 4
) (
  input  logic signed [N-1:0]   M,
  input  logic signed [N-1:0]   Q,
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic signed [2*N-1:0] Y,
  output logic                  valid
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [N-1:0]  m_reg;
  logic [N-1:0]  q_reg;
  logic [N:0]    acc;
  logic          q_m1;
  logic [CW-1:0] count;

  logic [N:0]    m_ext;
  logic [N:0]    sum;
  logic [N:0]    acc_step;
  logic [N-1:0]  q_step;
  logic          last_step;

  // One extra accumulator bit keeps -M exact when M is the most negative value.
  always_comb begin
    m_ext = {m_reg[N-1], m_reg};
    case ({q_reg[0], q_m1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
    acc_step  = {sum[N], sum[N:1]};
    q_step    = {sum[0], q_reg[N-1:1]};
    last_step = (count == CW'(1));
  end

  always_comb begin
    state_next = state;
    valid      = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: begin
        valid      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      Y     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= M;
            q_reg <= Q;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CW'(N);
          end
        end
        RUN: begin
          acc   <= acc_step;
          q_reg <= q_step;
          q_m1  <= q_reg[0];
          count <= count - CW'(1);
          if (last_step) Y <= {acc_step[N-1:0], q_step};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booths_multiplication.sv
// Directed-vector bench for booths_multiplication (N=4).
module tb_booths_multiplication;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] m_in;
  logic [3:0] q_in;
  logic [7:0] y;
  logic       valid;

  int total;
  int bad;

  booths_multiplication #(.N(4)) dut (
    .M     (m_in),
    .Q     (q_in),
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Y     (y),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start pulse and waits (bounded) for valid; returns at the negedge where valid is seen.
  task automatic do_mult(input logic [3:0] m, input logic [3:0] q,
                         output int lat, output logic [7:0] y_first);
    @(negedge clk);
    m_in  = m;
    q_in  = q;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    y_first = y;
    lat     = 0;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    m_in  = 4'd5;
    q_in  = 4'd7;
    repeat (2) @(negedge clk);
    total++;
    if (y !== 8'h00) begin bad++; $display("FAIL reset_y: got %h want 00", y); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL reset_no_pulse: got %b want 0 at cycle %0d", valid, i); end
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] yf;
    do_mult(4'd5, 4'd7, lat, yf);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    total++;
    if (y !== 8'h23) begin bad++; $display("FAIL basic_5x7: got %h want 23", y); end
    @(negedge clk);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got %b want 0", valid); end
  endtask

  task automatic test_negative();
    int lat;
    logic [7:0] yf;
    do_mult(4'hC, 4'd6, lat, yf);
    total++;
    if (yf !== 8'h23) begin bad++; $display("FAIL neg_y_hold: got %h want 23", yf); end
    total++;
    if (y !== 8'hE8) begin bad++; $display("FAIL neg_m4x6: got %h want e8", y); end
    @(negedge clk);
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL neg_pulse_width: got %b want 0", valid); end
    total++;
    if (y !== 8'hE8) begin bad++; $display("FAIL neg_y_after: got %h want e8", y); end
  endtask

  task automatic test_mixed();
    int lat;
    logic [7:0] yf;
    do_mult(4'hD, 4'hB, lat, yf);
    total++;
    if (y !== 8'h0F) begin bad++; $display("FAIL mixed_m3xm5: got %h want 0f", y); end
    do_mult(4'd2, 4'h8, lat, yf);
    total++;
    if (y !== 8'hF0) begin bad++; $display("FAIL mixed_2xm8: got %h want f0", y); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL mixed_latency: got %0d want 4", lat); end
  endtask

  task automatic test_boundary();
    int lat;
    logic [7:0] yf;
    do_mult(4'h8, 4'h8, lat, yf);
    total++;
    if (y !== 8'h40) begin bad++; $display("FAIL bound_m8xm8: got %h want 40", y); end
    do_mult(4'h8, 4'd1, lat, yf);
    total++;
    if (y !== 8'hF8) begin bad++; $display("FAIL bound_m8x1: got %h want f8", y); end
    do_mult(4'd0, 4'h8, lat, yf);
    total++;
    if (y !== 8'h00) begin bad++; $display("FAIL bound_0xm8: got %h want 00", y); end
  endtask

  task automatic test_busy();
    int lat;
    @(negedge clk);
    m_in  = 4'd3;
    q_in  = 4'd2;
    start = 1'b1;
    @(negedge clk);
    m_in = 4'd7;
    q_in = 4'd7;
    @(negedge clk);
    start = 1'b0;
    m_in  = 4'hF;
    q_in  = 4'hF;
    lat   = 1;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL busy_latency: got %0d want 4", lat); end
    total++;
    if (y !== 8'h06) begin bad++; $display("FAIL busy_3x2: got %h want 06", y); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL busy_no_queue: got %b want 0 at cycle %0d", valid, i); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] yf;
    do_mult(4'd2, 4'd3, lat, yf);
    total++;
    if (y !== 8'h06) begin bad++; $display("FAIL b2b_first: got %h want 06", y); end
    m_in  = 4'hE;
    q_in  = 4'd3;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat + 2 !== 6) begin bad++; $display("FAIL b2b_period: got %0d want 6", lat + 2); end
    total++;
    if (y !== 8'hFA) begin bad++; $display("FAIL b2b_m2x3: got %h want fa", y); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] yf;
    @(negedge clk);
    m_in  = 4'd5;
    q_in  = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (y !== 8'h00) begin bad++; $display("FAIL rstmid_y: got %h want 00", y); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_pulse: got %b want 0 at cycle %0d", valid, i); end
    end
    do_mult(4'd3, 4'd3, lat, yf);
    total++;
    if (y !== 8'h09) begin bad++; $display("FAIL rstmid_3x3: got %h want 09", y); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL rstmid_latency: got %0d want 4", lat); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    m_in  = '0;
    q_in  = '0;
    test_reset();
    test_basic();
    test_negative();
    test_mixed();
    test_boundary();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
